// File: rtl/product_bcd_converter_pkg.sv
// -----------------------------------------------------------------------------
// product_bcd_converter_pkg
// Shared definitions for the product binary-to-BCD converter:
//   - state_t        : converter FSM encoding (IDLE, SHIFT, DONE)
//   - ADD3_THRESHOLD : digit value at or above which the add-3 correction applies
//   - ADD3_VALUE     : correction added to a digit before each shift
//   - BCD_BLANK      : code the display driver decodes as an unlit digit
// -----------------------------------------------------------------------------
package product_bcd_converter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;
    localparam logic [3:0] ADD3_VALUE     = 4'd3;
    localparam logic [3:0] BCD_BLANK      = 4'hF;

endpackage : product_bcd_converter_pkg

// File: rtl/product_bcd_converter_bcd_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
// Combinational double-dabble correction for one BCD digit: a digit of 5..9
// gets +3 so that the following left shift carries correctly into the next
// decade. Inputs never exceed 9, so the 4-bit sum cannot overflow.
// Ports:
//   digit_in  [3:0] : scratch digit before the shift
//   digit_out [3:0] : corrected digit
// -----------------------------------------------------------------------------
module bcd_digit_adjust
    import product_bcd_converter_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // Add-3 correction ahead of the shift.
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= ADD3_THRESHOLD) begin
            digit_out = digit_in + ADD3_VALUE;
        end else begin
            digit_out = digit_in;
        end
    end

endmodule : bcd_digit_adjust

// File: rtl/product_bcd_converter.sv
// -----------------------------------------------------------------------------
// product_bcd_converter
// Sequential binary-to-BCD converter (shift-add-3 / double dabble) for the
// 8-bit multiplier product. One product bit is consumed per clock; a one-cycle
// done pulse accompanies freshly updated digits. Digit outputs only change on
// completion, so the display never shows intermediate values.
//
// Optional build macro:
//   PRODUCT_BCD_BLANK_EN : leading-zero blanking. A zero hundreds digit is
//                          output as 4'hF; a zero tens digit is output as 4'hF
//                          when hundreds is also zero. Ones is never blanked.
//
// Ports:
//   clk          : system clock, rising edge
//   rst          : asynchronous, active-high reset
//   start        : conversion request, honoured only while idle
//   product      : binary value, captured on the accepted start cycle
//   busy         : high from the cycle after acceptance through the DONE cycle
//   done         : one-cycle pulse, digits are updated in this cycle
//   bcd_hundreds : most significant BCD digit
//   bcd_tens     : middle BCD digit
//   bcd_ones     : least significant BCD digit
// -----------------------------------------------------------------------------
module product_bcd_converter
    import product_bcd_converter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int ITER_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] product,
    output logic             busy,
    output logic             done,
    output logic [3:0]       bcd_hundreds,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones
);

    localparam int BCD_W = DIGITS * 4;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [WIDTH-1:0]    bin_r;
    logic [BCD_W-1:0]    scratch_r;
    logic [ITER_W-1:0]   iter_r;
    logic [BCD_W-1:0]    adj_s;
    logic [BCD_W+WIDTH-1:0] shifted_s;
    logic                last_iter_s;
    logic                busy_r;
    logic                done_r;
    logic [3:0]          hundreds_r;
    logic [3:0]          tens_r;
    logic [3:0]          ones_r;
    logic [3:0]          hundreds_nxt_s;
    logic [3:0]          tens_nxt_s;
    logic [3:0]          ones_nxt_s;

    // One add-3 corrector per scratch digit.
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adjust
            bcd_digit_adjust u_adjust (
                .digit_in  (scratch_r[g*4 +: 4]),
                .digit_out (adj_s[g*4 +: 4])
            );
        end
    endgenerate

    // Corrected digits and remaining product bits shift left together.
    assign shifted_s   = {adj_s, bin_r} << 1;
    assign last_iter_s = (iter_r == ITER_W'(WIDTH - 1));

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_iter_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Digit values presented at completion, with optional leading-zero blanking.
    always_comb begin
        hundreds_nxt_s = scratch_r[11:8];
        tens_nxt_s     = scratch_r[7:4];
        ones_nxt_s     = scratch_r[3:0];
`ifdef PRODUCT_BCD_BLANK_EN
        if (scratch_r[11:8] == 4'd0) begin
            hundreds_nxt_s = BCD_BLANK;
        end else begin
            hundreds_nxt_s = scratch_r[11:8];
        end
        if ((scratch_r[11:8] == 4'd0) && (scratch_r[7:4] == 4'd0)) begin
            tens_nxt_s = BCD_BLANK;
        end else begin
            tens_nxt_s = scratch_r[7:4];
        end
`else
        hundreds_nxt_s = scratch_r[11:8];
        tens_nxt_s     = scratch_r[7:4];
`endif
    end

    // FSM state and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
            done_r  <= (state_r == DONE);
        end
    end

    // Conversion datapath: load, shift-add-3, and output digit capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_r      <= '0;
            scratch_r  <= '0;
            iter_r     <= '0;
            hundreds_r <= 4'h0;
            tens_r     <= 4'h0;
            ones_r     <= 4'h0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        bin_r     <= product;
                        scratch_r <= '0;
                        iter_r    <= '0;
                    end
                end
                SHIFT: begin
                    {scratch_r, bin_r} <= shifted_s;
                    iter_r             <= iter_r + ITER_W'(1);
                end
                DONE: begin
                    hundreds_r <= hundreds_nxt_s;
                    tens_r     <= tens_nxt_s;
                    ones_r     <= ones_nxt_s;
                end
                default: begin
                    iter_r <= '0;
                end
            endcase
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign bcd_hundreds = hundreds_r;
    assign bcd_tens     = tens_r;
    assign bcd_ones     = ones_r;

endmodule : product_bcd_converter

// File: tb/tb_product_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_product_bcd_converter
// Table-driven bench for product_bcd_converter, plus a hand-written
// mid-conversion reset sequence. Expected digits are hand-computed; in a
// PRODUCT_BCD_BLANK_EN build the leading zeros are replaced by 4'hF.
// -----------------------------------------------------------------------------
module tb_product_bcd_converter;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] product;
    logic       busy;
    logic       done;
    logic [3:0] bcd_hundreds;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;

    int checks = 0;
    int errors = 0;

    product_bcd_converter #(.WIDTH(8), .DIGITS(3), .ITER_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .product      (product),
        .busy         (busy),
        .done         (done),
        .bcd_hundreds (bcd_hundreds),
        .bcd_tens     (bcd_tens),
        .bcd_ones     (bcd_ones)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] p;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        bit         b2b;       // start in the IDLE cycle carrying the previous done
        int         pulse_at;  // cycle after acceptance for an extra start (0 = none)
        logic [7:0] pulse_p;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] exp_digits(input logic [3:0] h, input logic [3:0] t,
                                               input logic [3:0] o);
        logic [3:0] eh;
        logic [3:0] et;
        eh = h;
        et = t;
`ifdef PRODUCT_BCD_BLANK_EN
        if (h == 4'd0) eh = 4'hF;
        if (h == 4'd0 && t == 4'd0) et = 4'hF;
`endif
        return {eh, et, o};
    endfunction

    // Starts a conversion on the current (falling-edge) cycle and follows it to done.
    task automatic run_conv(input logic [7:0] p, input int pulse_at, input logic [7:0] pulse_p,
                            input logic [11:0] exp_d, input logic [11:0] hold_d,
                            input string tag);
        int lat = 0;
        int busy_cnt = 0;
        bit held = 1'b1;
        start   = 1'b1;
        product = p;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start   = 1'b0;
            product = 8'hA5;
            if (i == pulse_at) begin
                start   = 1'b1;
                product = pulse_p;
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            if ({bcd_hundreds, bcd_tens, bcd_ones} !== hold_d) held = 1'b0;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd10);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd9);
        chk({tag, "_digits"}, {20'd0, bcd_hundreds, bcd_tens, bcd_ones}, {20'd0, exp_d});
        chk({tag, "_digits_held"}, {31'd0, held}, 32'd1);
    endtask

    logic [11:0] prev_d;
    int          done_cnt;

    initial begin
        vecs[0] = '{8'd0,   4'd0, 4'd0, 4'd0, 1'b0, 0, 8'd0};
        vecs[1] = '{8'd225, 4'd2, 4'd2, 4'd5, 1'b0, 0, 8'd0};
        vecs[2] = '{8'd255, 4'd2, 4'd5, 4'd5, 1'b0, 0, 8'd0};
        vecs[3] = '{8'd100, 4'd1, 4'd0, 4'd0, 1'b1, 0, 8'd0};
        vecs[4] = '{8'd9,   4'd0, 4'd0, 4'd9, 1'b0, 3, 8'd42};
        vecs[5] = '{8'd99,  4'd0, 4'd9, 4'd9, 1'b0, 0, 8'd0};
        vecs[6] = '{8'd10,  4'd0, 4'd1, 4'd0, 1'b0, 0, 8'd0};
        vecs[7] = '{8'd196, 4'd1, 4'd9, 4'd6, 1'b0, 0, 8'd0};

        rst     = 1'b1;
        start   = 1'b0;
        product = 8'd0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_digits", {20'd0, bcd_hundreds, bcd_tens, bcd_ones}, 32'd0);
        rst    = 1'b0;
        prev_d = 12'h000;

        for (int v = 0; v < 8; v++) begin
            if (!vecs[v].b2b) begin
                @(negedge clk);
                chk($sformatf("v%0d_done_pulse_width", v), {31'd0, done}, 32'd0);
            end
            run_conv(vecs[v].p, vecs[v].pulse_at, vecs[v].pulse_p,
                     exp_digits(vecs[v].h, vecs[v].t, vecs[v].o), prev_d,
                     $sformatf("v%0d_p%0d", v, vecs[v].p));
            prev_d = exp_digits(vecs[v].h, vecs[v].t, vecs[v].o);
            if (vecs[v].pulse_at != 0) begin
                done_cnt = 0;
                for (int i = 0; i < 12; i++) begin
                    @(negedge clk);
                    if (done === 1'b1) done_cnt++;
                end
                chk($sformatf("v%0d_ignored_start_no_done", v), 32'(done_cnt), 32'd0);
            end
        end

        // Reset mid-conversion: abort at SHIFT cycle 5, no done follows.
        @(negedge clk);
        start   = 1'b1;
        product = 8'd77;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_abort_busy", {31'd0, busy}, 32'd1);
        chk("pre_abort_digits_held", {20'd0, bcd_hundreds, bcd_tens, bcd_ones}, {20'd0, prev_d});
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_digits", {20'd0, bcd_hundreds, bcd_tens, bcd_ones}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        run_conv(8'd77, 0, 8'd0, exp_digits(4'd0, 4'd7, 4'd7), 12'h000, "after_abort_p77");
        @(negedge clk);
        chk("after_abort_done_pulse_width", {31'd0, done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_product_bcd_converter
